// File: rtl/tick_gen_pkg.sv
// Shared constants, channel state type and width helper for prog_tick_gen.
// No logic; timing is set by the modules that import it.
package tick_gen_pkg;

  localparam int unsigned ONE_SEC_PERIOD  = 100_000_000;
  localparam int unsigned DEBOUNCE_PERIOD = 2_000_000;   // 20 ms at 100 MHz
  localparam int unsigned SCAN_PERIOD     = 100_000;     // 1 ms display/keypad scan

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ch_state_e;

  // Channel-select width; a single-channel build still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One divider channel: counter, active/shadow period, registered tick and square wave.
// Latency: outputs are registered, one edge after the counter state; no backpressure (load is gated upstream by pending).
module tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W      = 27,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(ONE_SEC_PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             sq,
  output logic             pending
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period, period_nxt;
  logic [CNT_W-1:0] shadow, shadow_nxt;
  logic             pend_nxt, tick_nxt, sq_nxt;
  logic             wrap, swap;
  ch_state_e        state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      period  <= RST_PERIOD;
      shadow  <= RST_PERIOD;
      pending <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      period  <= period_nxt;
      shadow  <= shadow_nxt;
      pending <= pend_nxt;
      tick    <= tick_nxt;
      sq      <= sq_nxt;
    end
  end

  always_comb begin
    state      = (period == '0) ? HALT : RUN;
    wrap       = (cnt == period - CNT_W'(1));
    swap       = 1'b0;
    cnt_nxt    = cnt;
    period_nxt = period;
    shadow_nxt = shadow;
    pend_nxt   = pending;
    tick_nxt   = 1'b0;
    sq_nxt     = sq;

    if (clr) begin
      cnt_nxt = '0;
      sq_nxt  = 1'b0;
      swap    = pending;
    end else if (en) begin
      if (state == HALT) begin
        cnt_nxt = '0;
        sq_nxt  = 1'b0;
        swap    = pending;
      end else if (wrap) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        swap     = pending;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end

    // New period only ever lands on a boundary, so no short or long period is emitted.
    if (swap) begin
      period_nxt = shadow;
      pend_nxt   = 1'b0;
    end

    if (en && !clr && state == RUN) begin
      sq_nxt = (cnt_nxt >= (period_nxt >> 1));
    end

    if (load) begin
      shadow_nxt = load_val;
      pend_nxt   = 1'b1;
    end
  end

endmodule

// File: rtl/prog_tick_gen.sv
// NUM_CH programmable tick/square-wave channels plus a free-running counter bus.
// Latency: tick/sq/cfg_err registered; cfg_ready is combinational and refuses writes to a channel with a pending period.
module prog_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 27,
  parameter int unsigned DEFAULT_PERIOD = ONE_SEC_PERIOD,
  parameter int          FREE_W         = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      cfg_we,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]          cfg_period,
  output logic                      cfg_ready,
  output logic                      cfg_err,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         sq,
  output logic [FREE_W-1:0]         free_cnt
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] load;

  // Out-of-range selects match no channel, so they are never ready.
  always_comb begin
    cfg_ready = 1'b0;
    load      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pending[i];
        load[i]   = cfg_we && !pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_gen_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (CNT_W'(DEFAULT_PERIOD))
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .load     (load[g]),
      .load_val (cfg_period),
      .tick     (tick[g]),
      .sq       (sq[g]),
      .pending  (pending[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err  <= 1'b0;
      free_cnt <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_ready;
      if (clr) begin
        free_cnt <= '0;
      end else if (en) begin
        free_cnt <= free_cnt + FREE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_tick_gen.sv
// Directed bench for prog_tick_gen: 3 channels, 8-bit counters, default period 4.
module tb_prog_tick_gen;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_ready, cfg_err;
  logic [2:0] pending, tick, sq;
  logic [7:0] free_cnt;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_free = 8'd0;

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [7:0] per;
    logic       rdy;
    logic [2:0] tk;
    logic [2:0] sqv;
    logic [2:0] pd;
    logic       err;
    logic [7:0] fc;
  } vec_t;

  vec_t vt [12];
  int   sq5 [6] = '{0, 0, 1, 1, 1, 0};
  int   tk5 [6] = '{1, 0, 0, 0, 0, 1};
  int   tk3 [3] = '{0, 0, 1};
  int   sq3 [3] = '{1, 1, 0};

  always #5 clk = ~clk;

  prog_tick_gen #(
    .NUM_CH(3), .CNT_W(8), .DEFAULT_PERIOD(4), .FREE_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .pending(pending), .tick(tick), .sq(sq),
    .free_cnt(free_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (clr) exp_free = 8'd0;
    else if (en) exp_free = exp_free + 8'd1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] p);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    // edges 13..24: write ch1=6, rejected rewrite, ch2=2 accepted as ch1 swaps
    vt[0]  = '{1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 8'd13};
    vt[1]  = '{1'b1, 2'd1, 8'd6, 1'b1, 3'b000, 3'b111, 3'b010, 1'b0, 8'd14};
    vt[2]  = '{1'b1, 2'd1, 8'd9, 1'b0, 3'b000, 3'b111, 3'b010, 1'b1, 8'd15};
    vt[3]  = '{1'b1, 2'd2, 8'd2, 1'b1, 3'b111, 3'b000, 3'b100, 1'b0, 8'd16};
    vt[4]  = '{1'b0, 2'd2, 8'd0, 1'b0, 3'b000, 3'b000, 3'b100, 1'b0, 8'd17};
    vt[5]  = '{1'b0, 2'd2, 8'd0, 1'b0, 3'b000, 3'b101, 3'b100, 1'b0, 8'd18};
    vt[6]  = '{1'b0, 2'd2, 8'd0, 1'b0, 3'b000, 3'b111, 3'b100, 1'b0, 8'd19};
    vt[7]  = '{1'b0, 2'd2, 8'd0, 1'b0, 3'b101, 3'b010, 3'b000, 1'b0, 8'd20};
    vt[8]  = '{1'b0, 2'd2, 8'd0, 1'b1, 3'b000, 3'b110, 3'b000, 1'b0, 8'd21};
    vt[9]  = '{1'b0, 2'd2, 8'd0, 1'b1, 3'b110, 3'b001, 3'b000, 1'b0, 8'd22};
    vt[10] = '{1'b0, 2'd2, 8'd0, 1'b1, 3'b000, 3'b101, 3'b000, 1'b0, 8'd23};
    vt[11] = '{1'b0, 2'd2, 8'd0, 1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 8'd24};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_period = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_sq", 32'(sq), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_free", 32'(free_cnt), 32'h0);
    chk("rst_rdy", 32'(cfg_ready), 32'h1);

    rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("p1_tick_e%0d", k), 32'(tick), (k % 4 == 0) ? 32'h7 : 32'h0);
      chk($sformatf("p1_sq_e%0d", k), 32'(sq), (k % 4 >= 2) ? 32'h7 : 32'h0);
    end
    chk("p1_free12", 32'(free_cnt), 32'd12);

    for (int i = 0; i < 12; i++) begin
      cfg_we = vt[i].we; cfg_ch = vt[i].ch; cfg_period = vt[i].per;
      #1;
      chk($sformatf("tab%0d_rdy", i), 32'(cfg_ready), 32'(vt[i].rdy));
      step();
      chk($sformatf("tab%0d_tick", i), 32'(tick), 32'(vt[i].tk));
      chk($sformatf("tab%0d_sq", i), 32'(sq), 32'(vt[i].sqv));
      chk($sformatf("tab%0d_pend", i), 32'(pending), 32'(vt[i].pd));
      chk($sformatf("tab%0d_err", i), 32'(cfg_err), 32'(vt[i].err));
      chk($sformatf("tab%0d_free", i), 32'(free_cnt), 32'(vt[i].fc));
    end
    cfg_we = 1'b0;

    // ch0 -> P=0 lands at its next boundary, then halts
    wr(2'd0, 8'd0);
    chk("halt_pend_set", 32'(pending[0]), 32'h1);
    step(); step(); step();
    chk("halt_last_tick", 32'(tick[0]), 32'h1);
    chk("halt_pend_clr", 32'(pending[0]), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("halt_tick%0d", k), 32'(tick[0]), 32'h0);
      chk($sformatf("halt_sq%0d", k), 32'(sq[0]), 32'h0);
    end
    wr(2'd0, 8'd1);
    chk("p1_pend_set", 32'(pending[0]), 32'h1);
    chk("p1_tick_wr", 32'(tick[0]), 32'h0);
    step();
    chk("p1_pend_clr", 32'(pending[0]), 32'h0);
    chk("p1_tick_load", 32'(tick[0]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("p1_tick%0d", k), 32'(tick[0]), 32'h1);
      chk($sformatf("p1_sq%0d", k), 32'(sq[0]), 32'h1);
    end
    wr(2'd0, 8'd5);
    chk("p5_tick_wr", 32'(tick[0]), 32'h1);
    chk("p5_pend_set", 32'(pending[0]), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("p5_sq%0d", k), 32'(sq[0]), 32'(sq5[k]));
      chk($sformatf("p5_tick%0d", k), 32'(tick[0]), 32'(tk5[k]));
    end
    chk("p5_pend_clr", 32'(pending[0]), 32'h0);

    // en low mid-period: everything freezes, phase resumes
    step(); step();
    chk("en_pre_sq", 32'(sq[0]), 32'h1);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("en0_tick%0d", k), 32'(tick), 32'h0);
      chk($sformatf("en0_sq%0d", k), 32'(sq[0]), 32'h1);
      chk($sformatf("en0_free%0d", k), 32'(free_cnt), 32'(exp_free));
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("en1_tick%0d", k), 32'(tick[0]), 32'(tk3[k]));
      chk($sformatf("en1_sq%0d", k), 32'(sq[0]), 32'(sq3[k]));
    end

    // clr with a pending period: new P active right after the clear
    wr(2'd0, 8'd3);
    chk("clr_pend_set", 32'(pending[0]), 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_tick", 32'(tick), 32'h0);
    chk("clr_sq", 32'(sq), 32'h0);
    chk("clr_pend", 32'(pending), 32'h0);
    chk("clr_free", 32'(free_cnt), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("clr_p3_tick%0d", k), 32'(tick[0]), 32'(tk3[k]));
      chk($sformatf("clr_p3_sq%0d", k), 32'(sq[0]), 32'(sq3[k]));
      chk($sformatf("clr_p3_free%0d", k), 32'(free_cnt), 32'(exp_free));
    end

    // asynchronous reset between edges
    wr(2'd1, 8'd7);
    chk("arst_pre_pend", 32'(pending), 32'h2);
    chk("arst_pre_sq", 32'(sq[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_sq", 32'(sq), 32'h0);
    chk("arst_pend", 32'(pending), 32'h0);
    chk("arst_free", 32'(free_cnt), 32'h0);
    chk("arst_err", 32'(cfg_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_free = 8'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arst_def_tick%0d", k), 32'(tick[0]), (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("arst_free%0d", k), 32'(free_cnt), 32'(exp_free));
    end

    // select beyond NUM_CH
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd5;
    #1;
    chk("oor_rdy", 32'(cfg_ready), 32'h0);
    step();
    cfg_we = 1'b0;
    chk("oor_err", 32'(cfg_err), 32'h1);
    chk("oor_pend", 32'(pending), 32'h0);
    step();
    chk("oor_err_drop", 32'(cfg_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
